hsv2rgb: RTL
============

Name: hsv2rgb

Overview:
- Inverse of the camera-path RGB→HSV stage. Takes a pixel stream in HSV form (H 0..359 degrees, S 0..256 as 1.8 fixed point, V 0..255) with its video syncs and produces packed 24-bit RGB888 on the same timing.
- Used to re-colour pixels after HSV-domain processing, such as hue shift or skin masking, before display.
- Fixed-latency pipeline with sync/de delay lines kept cycle-aligned to the data.

Parameters:
- BLANK_ZERO, 1, when 1 rgb_data is forced to 24'h0 on any output cycle where rgb_de=0; when 0 pipeline data passes through unchanged.

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous, active-high reset
- hsv_vsync  input  1  frame sync in
- hsv_hsync  input  1  line sync in
- hsv_de  input  1  data enable in
- hsv_h  input  9  hue, 0..359
- hsv_s  input  9  saturation, 0..256 (256 = 1.0)
- hsv_v  input  8  value, 0..255
- rgb_vsync  output  1  hsv_vsync delayed by 4 cycles
- rgb_hsync  output  1  hsv_hsync delayed by 4 cycles
- rgb_de  output  1  hsv_de delayed by 4 cycles
- rgb_data  output  24  {R[23:16], G[15:8], B[7:0]}

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port rst. While rst=1 at a clk edge, every pipeline register, every delay-line bit and all outputs clear to 0.
- Latency: exactly 4 cycles. Inputs sampled at edge N appear on the outputs after edge N+4. Throughput is one pixel per cycle with no stalls; the pipeline always advances.
- Input conditioning (stage 1):
  - hsv_h >= 360 is treated as 0.
  - hsv_s > 256 saturates to 256.
  - Sector k = floor(h/60), in 0..5, computed by compare chain; f = h - 60k, in 0..59.
- Stage 2: chroma c = (v*s) >> 8, 8 bits. c <= v is guaranteed.
- Stage 3: t = floor(c*f/60). Must be bit-exact for all c 0..255 and f 0..59; a reciprocal multiply is allowed only if exact over that range.
- Stage 4:
  - p = v - c; rise = p + t; fall = v - t. All values are 0..255, so no overflow.
  - (R,G,B) by sector: 0 → (v, rise, p); 1 → (fall, v, p); 2 → (p, v, rise); 3 → (p, fall, v); 4 → (rise, p, v); 5 → (v, p, fall).
  - Result is registered into rgb_data.
- Syncs: vsync, hsync and de each pass through a 4-deep shift register cleared by rst. No edge detection and no reshaping.
- Blanking: data computes regardless of hsv_de. BLANK_ZERO only masks the output.
- Reset mid-frame: in-flight pixels are discarded. The first valid output appears 4 cycles after the first de=1 input following rst deassertion.

Optional Feature:
- Macro HSV2RGB_ROUND_EN.
- Defined: c = (v*s + 128) >> 8 and t = floor((c*f + 30)/60), i.e. round-to-nearest. c <= v and t <= c still hold.
- Undefined: truncating arithmetic as above.
- Latency is unchanged either way.

Decomposition:
- Package hsv_pkg holds:
  - constants HSV_H_RANGE=360, HSV_S_ONE=256, HSV_SECTOR=60, HSV2RGB_LAT=4;
  - typedef for the 3-bit sector code.
- One sub-module: hsv_sync_delay.
  - Parameter DEPTH.
  - Shift register for {vsync, hsync, de} with synchronous active-high reset.
  - Instantiated with DEPTH=HSV2RGB_LAT.

Test Plan:
- Primaries: h=0,s=256,v=255 → rgb_data 24'hFF0000 exactly 4 cycles later. Then h=120 → 24'h00FF00 and h=240 → 24'h0000FF.
- Mid-sector: h=30,s=256,v=200 (c=200, f=30, t=100) → 24'hC86400. Also h=300,s=128,v=200 → 24'hC864C8.
- Grey and clamps:
  - s=0, v=128, any h → 24'h808080.
  - h=400, s=256, v=255 → 24'hFF0000 (treated as h=0).
  - s=300, h=0, v=255 → 24'hFF0000 (saturated to 256).
- Rounding: h=0, s=128, v=255 → 24'hFF8080 without the macro; 24'hFF7F7F with HSV2RGB_ROUND_EN defined.
- Syncs: a 1-cycle hsv_vsync pulse, a 3-cycle hsv_hsync pulse and a de toggle pattern reappear on rgb_* delayed exactly 4 cycles. With BLANK_ZERO=1, rgb_data=0 whenever rgb_de=0.
- Reset: stream a continuous ramp, assert rst for 1 cycle mid-line.
  - All outputs are 0 after that edge.
  - Old pixels never emerge after reset.
  - New pixels resume with 4-cycle latency.

Source files
------------

// File: rtl/hsv_pkg.sv
// Shared constants, sector encoding and a divide-by-60 helper for the
// HSV -> RGB converter.
package hsv_pkg;

    localparam logic [8:0] HSV_H_RANGE = 9'd360;
    localparam logic [8:0] HSV_S_ONE   = 9'd256;
    localparam logic [8:0] HSV_SECTOR  = 9'd60;
    localparam int         HSV2RGB_LAT = 4;

    // Hue sector, one per 60 degrees.
    typedef enum logic [2:0] {
        SEC_0 = 3'd0,
        SEC_1 = 3'd1,
        SEC_2 = 3'd2,
        SEC_3 = 3'd3,
        SEC_4 = 3'd4,
        SEC_5 = 3'd5
    } hsv_sector_e;

    // x / 60 as multiply by ceil(2^20 / 60) then shift right by 20.
    // The overshoot stays below 1/60 for every x < 23831. The largest
    // input is 255 * 59 + 30 = 15075, so the floor is exact over the
    // whole range.
    localparam logic [31:0] DIV60_MUL   = 32'd17477;
    localparam int          DIV60_SHIFT = 20;

    function automatic logic [7:0] div60(input logic [15:0] x);
        logic [31:0] prod;
        prod = {16'd0, x} * DIV60_MUL;
        return 8'(prod >> DIV60_SHIFT);
    endfunction

endpackage

// File: rtl/hsv_sync_delay.sv
// Fixed-depth delay line for {vsync, hsync, de}. It keeps the video
// timing aligned with the pixel pipeline. Synchronous active-high reset.
module hsv_sync_delay #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_vsync,
    input  logic in_hsync,
    input  logic in_de,
    output logic out_vsync,
    output logic out_hsync,
    output logic out_de
);

    logic [2:0] sync_d [DEPTH];
    logic [2:0] sync_q [DEPTH];

    // Next state: new sample enters tap 0, every tap moves one step on.
    always_comb begin
        sync_d[0] = {in_vsync, in_hsync, in_de};
        for (int i = 1; i < DEPTH; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Shift register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sync_q[i] <= 3'b000;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign {out_vsync, out_hsync, out_de} = sync_q[DEPTH-1];

endmodule

// File: rtl/hsv2rgb.sv
// HSV -> RGB888 pixel converter. It is a 4-stage pipeline with no stalls.
// Stage 1 conditions the inputs and splits the hue into sector and offset.
// Stage 2 forms the chroma, stage 3 forms the ramp term, and stage 4
// selects the channels.
// Optional macro HSV2RGB_ROUND_EN: when defined, the chroma and ramp
// terms round to nearest instead of truncating. Latency is 4 either way.
module hsv2rgb
    import hsv_pkg::*;
#(
    parameter bit BLANK_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsv_vsync,
    input  logic        hsv_hsync,
    input  logic        hsv_de,
    input  logic [8:0]  hsv_h,
    input  logic [8:0]  hsv_s,
    input  logic [7:0]  hsv_v,
    output logic        rgb_vsync,
    output logic        rgb_hsync,
    output logic        rgb_de,
    output logic [23:0] rgb_data
);

`ifdef HSV2RGB_ROUND_EN
    localparam logic [15:0] C_RND = 16'd128;
    localparam logic [15:0] T_RND = 16'd30;
`else
    localparam logic [15:0] C_RND = 16'd0;
    localparam logic [15:0] T_RND = 16'd0;
`endif

    localparam logic [8:0] H_060 = HSV_SECTOR;
    localparam logic [8:0] H_120 = 9'(2 * HSV_SECTOR);
    localparam logic [8:0] H_180 = 9'(3 * HSV_SECTOR);
    localparam logic [8:0] H_240 = 9'(4 * HSV_SECTOR);
    localparam logic [8:0] H_300 = 9'(5 * HSV_SECTOR);

    // stage 1
    hsv_sector_e sector1_d, sector1_q;
    logic [5:0]  f1_d, f1_q;
    logic [8:0]  s1_d, s1_q;
    logic [7:0]  v1_d, v1_q;
    logic [8:0]  h_c;
    logic [8:0]  h_base;

    // stage 2
    hsv_sector_e sector2_d, sector2_q;
    logic [5:0]  f2_d, f2_q;
    logic [7:0]  c2_d, c2_q;
    logic [7:0]  v2_d, v2_q;

    // stage 3
    hsv_sector_e sector3_d, sector3_q;
    logic [7:0]  t3_d, t3_q;
    logic [7:0]  c3_d, c3_q;
    logic [7:0]  v3_d, v3_q;

    // stage 4
    logic [23:0] rgb_d, rgb_q;
    logic [7:0]  p4, rise4, fall4;

    // Stage 1: fold out-of-range hue to 0, clamp saturation, find sector
    // and offset within the sector using a compare chain.
    always_comb begin
        h_c = (hsv_h >= HSV_H_RANGE) ? 9'd0 : hsv_h;
        s1_d = (hsv_s > HSV_S_ONE) ? HSV_S_ONE : hsv_s;
        v1_d = hsv_v;
        sector1_d = SEC_0;
        h_base    = 9'd0;
        if (h_c >= H_300) begin
            sector1_d = SEC_5;
            h_base    = H_300;
        end else if (h_c >= H_240) begin
            sector1_d = SEC_4;
            h_base    = H_240;
        end else if (h_c >= H_180) begin
            sector1_d = SEC_3;
            h_base    = H_180;
        end else if (h_c >= H_120) begin
            sector1_d = SEC_2;
            h_base    = H_120;
        end else if (h_c >= H_060) begin
            sector1_d = SEC_1;
            h_base    = H_060;
        end
        f1_d = 6'(h_c - h_base);
    end

    // Stage 1 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sector1_q <= SEC_0;
            f1_q      <= 6'd0;
            s1_q      <= 9'd0;
            v1_q      <= 8'd0;
        end else begin
            sector1_q <= sector1_d;
            f1_q      <= f1_d;
            s1_q      <= s1_d;
            v1_q      <= v1_d;
        end
    end

    // Stage 2: chroma c = (v*s [+128]) >> 8. s <= 256 keeps c <= v, and
    // 255*256+128 still fits in 16 bits.
    always_comb begin
        c2_d      = 8'(({8'd0, v1_q} * {7'd0, s1_q} + C_RND) >> 8);
        v2_d      = v1_q;
        f2_d      = f1_q;
        sector2_d = sector1_q;
    end

    // Stage 2 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sector2_q <= SEC_0;
            f2_q      <= 6'd0;
            c2_q      <= 8'd0;
            v2_q      <= 8'd0;
        end else begin
            sector2_q <= sector2_d;
            f2_q      <= f2_d;
            c2_q      <= c2_d;
            v2_q      <= v2_d;
        end
    end

    // Stage 3: ramp term t = (c*f [+30]) / 60.
    always_comb begin
        t3_d      = div60({8'd0, c2_q} * {10'd0, f2_q} + T_RND);
        c3_d      = c2_q;
        v3_d      = v2_q;
        sector3_d = sector2_q;
    end

    // Stage 3 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sector3_q <= SEC_0;
            t3_q      <= 8'd0;
            c3_q      <= 8'd0;
            v3_q      <= 8'd0;
        end else begin
            sector3_q <= sector3_d;
            t3_q      <= t3_d;
            c3_q      <= c3_d;
            v3_q      <= v3_d;
        end
    end

    // Stage 4: form the floor, rising and falling levels and route them to
    // R, G and B according to the sector. t <= c <= v keeps all three in 0..255.
    always_comb begin
        p4    = v3_q - c3_q;
        rise4 = p4 + t3_q;
        fall4 = v3_q - t3_q;
        rgb_d = 24'h0;
        case (sector3_q)
            SEC_0:   rgb_d = {v3_q,  rise4, p4};
            SEC_1:   rgb_d = {fall4, v3_q,  p4};
            SEC_2:   rgb_d = {p4,    v3_q,  rise4};
            SEC_3:   rgb_d = {p4,    fall4, v3_q};
            SEC_4:   rgb_d = {rise4, p4,    v3_q};
            SEC_5:   rgb_d = {v3_q,  p4,    fall4};
            default: rgb_d = 24'h0;
        endcase
    end

    // Output pixel register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= 24'h0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    hsv_sync_delay #(
        .DEPTH (HSV2RGB_LAT)
    ) u_sync_delay (
        .clk       (clk),
        .rst       (rst),
        .in_vsync  (hsv_vsync),
        .in_hsync  (hsv_hsync),
        .in_de     (hsv_de),
        .out_vsync (rgb_vsync),
        .out_hsync (rgb_hsync),
        .out_de    (rgb_de)
    );

    // The pixel pipeline runs regardless of de. The mask only hides blanking cycles.
    assign rgb_data = (BLANK_ZERO && !rgb_de) ? 24'h0 : rgb_q;

endmodule
